// File: rtl/riscv_defines.sv
// Shared constants for the interrupt arbiter: register map and line count.
// Also holds the ID-to-one-hot helper used for acknowledge decoding.
package riscv_defines;

    localparam int IRQ_LINES = 32;
    localparam int IRQ_ID_W  = 5;

    typedef enum logic [1:0] {
        CFG_MASK   = 2'd0,
        CFG_SET    = 2'd1,
        CFG_CLEAR  = 2'd2,
        CFG_SECURE = 2'd3
    } cfg_addr_e;

    function automatic logic [IRQ_LINES-1:0] id_to_onehot(input logic [IRQ_ID_W-1:0] id);
        logic [IRQ_LINES-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/riscv_irq_arbiter_if.sv
// Signal bundle between an interrupt arbiter and its config/core side.
// master drives lines, config writes and acks; slave returns read data and the selected interrupt.
interface riscv_irq_arbiter_if;
    logic [31:0] irq_lines;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq;
    logic [4:0]  irq_id;
    logic        irq_sec;
    logic        irq_ack;
    logic [4:0]  irq_ack_id;

    modport master (
        output irq_lines, cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_ack_id,
        input  cfg_rdata, irq, irq_id, irq_sec
    );

    modport slave (
        input  irq_lines, cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_ack_id,
        output cfg_rdata, irq, irq_id, irq_sec
    );
endinterface

// File: rtl/riscv_irq_prio_enc.sv
// Lowest-index-first priority encoder over 32 request bits.
// Purely combinational; idx is 0 when nothing is requesting.
module riscv_irq_prio_enc (
    input  logic [31:0] vec,
    output logic [4:0]  idx,
    output logic        vld
);

    // Scan high to low so the last hit, the lowest index, wins.
    always_comb begin
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
    end

    assign vld = |vec;

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Edge-triggered interrupt pending/mask/secure arbiter selecting the lowest pending ID.
// Latency: a line edge or SET write is visible on irq_o one cycle later; reads are combinational.
// Backpressure: none; pending bits hold until acked or cleared, set beats clear on the same bit.
module riscv_irq_arbiter
    import riscv_defines::*;
#(
    parameter int NUM_IRQ = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_lines_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [NUM_IRQ-1:0] cfg_wdata_i,
    output logic [NUM_IRQ-1:0] cfg_rdata_o,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    output logic               irq_sec_o,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_ack_id_i
);

    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] sec_q;
    logic               armed_q;

    logic               wr_mask;
    logic               wr_set;
    logic               wr_clr;
    logic               wr_sec;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] active;
    logic [4:0]         sel_id;
    logic               sel_vld;

    assign wr_mask = cfg_we_i && (cfg_addr_i == CFG_MASK);
    assign wr_set  = cfg_we_i && (cfg_addr_i == CFG_SET);
    assign wr_clr  = cfg_we_i && (cfg_addr_i == CFG_CLEAR);
    assign wr_sec  = cfg_we_i && (cfg_addr_i == CFG_SECURE);

    // armed_q blocks the first cycle after reset so a line already high is not seen as an edge.
    always_comb begin
        rise    = armed_q ? (irq_lines_i & ~prev_q) : '0;
        set_vec = rise | (wr_set ? cfg_wdata_i : '0);
        clr_vec = (wr_clr ? cfg_wdata_i : '0)
                | (irq_ack_i ? id_to_onehot(irq_ack_id_i) : '0);
        pend_d  = (pend_q & ~clr_vec) | set_vec;
        active  = pend_q & mask_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            sec_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= irq_lines_i;
            pend_q  <= pend_d;
            armed_q <= 1'b1;
            if (wr_mask) begin
                mask_q <= cfg_wdata_i;
            end
            if (wr_sec) begin
                sec_q <= cfg_wdata_i;
            end
        end
    end

    riscv_irq_prio_enc u_prio (
        .vec (active),
        .idx (sel_id),
        .vld (sel_vld)
    );

    assign irq_o     = sel_vld;
    assign irq_id_o  = sel_id;
    assign irq_sec_o = sec_q[sel_id] & sel_vld;

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            CFG_MASK:   cfg_rdata_o = mask_q;
            CFG_SET:    cfg_rdata_o = pend_q;
            CFG_CLEAR:  cfg_rdata_o = '0;
            CFG_SECURE: cfg_rdata_o = sec_q;
            default:    cfg_rdata_o = '0;
        endcase
    end

endmodule
